// File: rtl/sr_latch_pulse_ctrl_if.sv
// sr_latch_pulse_ctrl_if: requester handshake plus latch drive/status bundle.
// q_in and chk_err exist only when SR_READBACK_CHECK_EN is defined.
interface sr_latch_pulse_ctrl_if;
   logic set_req, clr_req, set_ack, clr_ack, S, R, busy, q_exp, q_exp_valid;
`ifdef SR_READBACK_CHECK_EN
   logic q_in, chk_err;
   modport master(
      output set_req, clr_req, q_in,
      input  set_ack, clr_ack, S, R, busy, q_exp, q_exp_valid, chk_err
   );
   modport slave(
      input  set_req, clr_req, q_in,
      output set_ack, clr_ack, S, R, busy, q_exp, q_exp_valid, chk_err
   );
`else
   modport master(
      output set_req, clr_req,
      input  set_ack, clr_ack, S, R, busy, q_exp, q_exp_valid
   );
   modport slave(
      input  set_req, clr_req,
      output set_ack, clr_ack, S, R, busy, q_exp, q_exp_valid
   );
`endif
endinterface

// File: rtl/sr_latch_pulse_ctrl.sv
// sr_latch_pulse_ctrl: arbitrated S/R pulse sequencer for a NOR SR latch, never drives S=R=1.
// Optional SR_READBACK_CHECK_EN adds a q_in readback compare with sticky chk_err.
module sr_latch_pulse_ctrl #(
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input logic clk,
   input logic rst_n,
   sr_latch_pulse_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;
   localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic s, s_n, r, r_n, op_set, op_set_n, last_set, last_set_n, q, q_n, qv, qv_n;
   logic gs, gc, done;
   // last_set=0 means the clear requester won last, so set takes the first tie
   assign gs   = rst_n && state == IDLE && bus.set_req && !(bus.clr_req && last_set);
   assign gc   = rst_n && state == IDLE && bus.clr_req && !gs;
   assign done = cnt == '0;
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      s_n        = s;
      r_n        = r;
      op_set_n   = op_set;
      last_set_n = last_set;
      q_n        = q;
      qv_n       = qv;
      case (state)
         IDLE: if (gs || gc) begin
            state_n  = PULSE;
            cnt_n    = P_LAST;
            s_n      = gs;
            r_n      = gc;
            op_set_n = gs;
            if (bus.set_req && bus.clr_req) last_set_n = gs;
         end
         PULSE: if (done) begin
            state_n = SETTLE;
            if (SETTLE_CYCLES == 0) state_n = IDLE;
            cnt_n = S_LAST;
            s_n   = 1'b0;
            r_n   = 1'b0;
            q_n   = op_set;
            qv_n  = 1'b1;
         end else cnt_n = cnt - CNT_W'(1);
         default: if (done) state_n = IDLE; else cnt_n = cnt - CNT_W'(1);
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         s        <= 1'b0;
         r        <= 1'b0;
         op_set   <= 1'b0;
         last_set <= 1'b0;
         q        <= 1'b0;
         qv       <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         s        <= s_n;
         r        <= r_n;
         op_set   <= op_set_n;
         last_set <= last_set_n;
         q        <= q_n;
         qv       <= qv_n;
      end
   assign bus.set_ack     = gs;
   assign bus.clr_ack     = gc;
   assign bus.S           = s;
   assign bus.R           = r;
   assign bus.busy        = state != IDLE;
   assign bus.q_exp       = q;
   assign bus.q_exp_valid = qv;
`ifdef SR_READBACK_CHECK_EN
   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SR_READBACK_CHECK_EN requires SETTLE_CYCLES >= 1");
   end
   logic err;
   // the latch has had the whole settle gap to resolve by the last settle cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else if (state == SETTLE && done && bus.q_in != q) err <= 1'b1;
   assign bus.chk_err = err;
`endif
endmodule

// File: tb/tb_sr_latch_pulse_ctrl.sv
// tb_sr_latch_pulse_ctrl: directed plus random requests on a default and a short-timing instance,
// checked against an age-since-grant reference model.
module tb_sr_latch_pulse_ctrl;
   localparam int P0 = 2, T0 = 2, P1 = 1;
`ifdef SR_READBACK_CHECK_EN
   localparam int T1 = 1;
`else
   localparam int T1 = 0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   sr_latch_pulse_ctrl_if b0(), b1();
   sr_latch_pulse_ctrl #(.PULSE_CYCLES(P0), .SETTLE_CYCLES(T0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   sr_latch_pulse_ctrl #(.PULSE_CYCLES(P1), .SETTLE_CYCLES(T1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   int vectors = 0, miscompares = 0;
   int pw[2] = '{P0, P1};
   int sw[2] = '{T0, T1};
   int age[2];
   bit cmd[2], mq[2], mv[2], last_set[2], merr[2], lq[2], mgs[2], mgc[2], oack_s[2], oack_c[2];
   bit sreq[2], creq[2];
   bit force0 = 1'b0;
   logic chk0, chk1;
   assign b0.set_req = sreq[0];
   assign b0.clr_req = creq[0];
   assign b1.set_req = sreq[1];
   assign b1.clr_req = creq[1];
`ifdef SR_READBACK_CHECK_EN
   assign b0.q_in = force0 ? 1'b0 : lq[0];
   assign b1.q_in = lq[1];
   assign chk0 = b0.chk_err;
   assign chk1 = b1.chk_err;
`else
   assign chk0 = 1'b0;
   assign chk1 = 1'b0;
`endif

   function automatic logic [7:0] obs(int d);
      if (d == 0) return {b0.set_ack, b0.clr_ack, b0.S, b0.R, b0.busy, b0.q_exp, b0.q_exp_valid, chk0};
      return {b1.set_ack, b1.clr_ack, b1.S, b1.R, b1.busy, b1.q_exp, b1.q_exp_valid, chk1};
   endfunction

   task automatic check(string tag, logic [31:0] o, logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic reset_model();
      for (int d = 0; d < 2; d++) begin
         age[d] = 1000;
         cmd[d] = 0;
         mq[d] = 0;
         mv[d] = 0;
         last_set[d] = 0;
         merr[d] = 0;
         mgs[d] = 0;
         mgc[d] = 0;
      end
   endtask

   // age = cycles since the grant cycle; drive during 1..P, busy during 1..P+T, q updates at P+1
   task automatic model_cycle(int d);
      bit idle, gs, gc, es, er;
      logic [7:0] o, e;
      idle = age[d] > pw[d] + sw[d];
      gs = idle && sreq[d] && !(creq[d] && last_set[d]);
      gc = idle && creq[d] && !gs;
      es = age[d] <= pw[d] && cmd[d];
      er = age[d] <= pw[d] && !cmd[d];
      e = {gs, gc, es, er, !idle, mq[d], mv[d], merr[d]};
      o = obs(d);
      check($sformatf("dut%0d_outputs", d), o, e);
      check($sformatf("dut%0d_s_and_r", d), o[5] & o[4], 0);
      oack_s[d] = o[7];
      oack_c[d] = o[6];
      mgs[d] = gs;
      mgc[d] = gc;
`ifdef SR_READBACK_CHECK_EN
      if (age[d] == pw[d] + sw[d] && ((d == 0 && force0) ? 1'b0 : lq[d]) != mq[d]) merr[d] = 1;
      if (es) lq[d] = 1;
      else if (er) lq[d] = 0;
`endif
      if (gs && creq[d]) last_set[d] = 1;
      else if (gc && sreq[d]) last_set[d] = 0;
      if (gs || gc) begin
         age[d] = 0;
         cmd[d] = gs;
      end
      if (age[d] < 1000) age[d]++;
      if (age[d] == pw[d] + 1) begin
         mq[d] = cmd[d];
         mv[d] = 1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(bit s, bit c);
      for (int d = 0; d < 2; d++) begin
         sreq[d] = 0;
         creq[d] = 0;
      end
      rst_n = 1'b0;
      reset_model();
      tick();
      for (int d = 0; d < 2; d++) begin
         sreq[d] = s;
         creq[d] = c;
      end
      rst_n = 1'b1;
   endtask

   task automatic rand_req(int d);
      if (mgs[d]) sreq[d] = $urandom_range(0, 2) == 0;
      else if (sreq[d]) sreq[d] = $urandom_range(0, 15) != 0;
      else sreq[d] = $urandom_range(0, 3) == 0;
      if (mgc[d]) creq[d] = $urandom_range(0, 2) == 0;
      else if (creq[d]) creq[d] = $urandom_range(0, 15) != 0;
      else creq[d] = $urandom_range(0, 3) == 0;
   endtask

   initial begin
      int n;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      do_reset(0, 0);
      // single set request held one cycle
      sreq[0] = 1;
      tick();
      sreq[0] = 0;
      repeat (6) tick();
      check("q_after_set", b0.q_exp, 1);
      // simultaneous requests held from reset exit alternate set/clear
      do_reset(1, 1);
      repeat (16) tick();
      for (int d = 0; d < 2; d++) begin
         sreq[d] = 0;
         creq[d] = 0;
      end
      repeat (8) tick();
      // clear request arriving during the second pulse cycle of a set
      sreq[0] = 1;
      tick();
      sreq[0] = 0;
      tick();
      creq[0] = 1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!oack_c[0] && n < 10);
      creq[0] = 0;
      check("clr_ack_delay", n, 4);
      repeat (6) tick();
      check("q_after_clr", b0.q_exp, 0);
      // asynchronous reset during the first S cycle
      sreq[0] = 1;
      tick();
      sreq[0] = 0;
      check("s_before_reset", b0.S, 1);
      #2 rst_n = 1'b0;
      #1;
      check("s_async_reset", b0.S, 0);
      check("valid_async_reset", b0.q_exp_valid, 0);
      check("busy_async_reset", b0.busy, 0);
      reset_model();
      @(posedge clk);
      #1;
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      // short-timing instance with set held
      sreq[1] = 1;
      n = 0;
      repeat (8) begin
         tick();
         n += int'(oack_s[1]);
      end
      sreq[1] = 0;
      check("dut1_grant_count", n, (8 + P1 + T1) / (1 + P1 + T1));
      repeat (4) tick();
      // mixed random requests with withdrawals on both instances
      repeat (300) begin
         rand_req(0);
         rand_req(1);
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         sreq[d] = 0;
         creq[d] = 0;
      end
      repeat (8) tick();
`ifdef SR_READBACK_CHECK_EN
      check("chk_err_clean", chk0, 0);
      sreq[0] = 1;
      tick();
      sreq[0] = 0;
      force0 = 1;
      repeat (8) tick();
      check("chk_err_sticky", chk0, 1);
      force0 = 0;
      do_reset(0, 0);
      check("chk_err_cleared", chk0, 0);
      repeat (4) tick();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
